// File: rtl/prog_loader_uart.sv
// prog_loader_uart: UART boot loader that fills program RAM and releases the CPU.
// Ports: clk/rst, rx_in line; ram_addr/ram_data/ram_we writes; cpu_hold, busy, err, byte_cnt status.
module prog_loader_uart #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic       cpu_hold,
  output logic       busy,
  output logic       err,
  output logic [8:0] byte_cnt
);

  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_e;
  typedef enum logic [2:0] {P_SYNC, P_LEN, P_DATA, P_CSUM, P_RUN} pstate_e;

  rstate_e     r_q, r_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        rx_valid_q, rx_valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_s, tick;

  assign rx_s = sync2_q;
  assign tick = (cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      r_q        <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= rx_in;
      sync2_q    <= sync1_q;
      prev_q     <= rx_s;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Start needs a falling edge, so a held-low line reports one
  // framing error and then waits for the line to go high again.
  always_comb begin
    r_d        = r_q;
    cnt_d      = tick ? cnt_q : cnt_q - 16'd1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    rx_valid_d = 1'b0;
    ferr_d     = 1'b0;
    unique case (r_q)
      R_IDLE: begin
        if (prev_q && !rx_s) begin
          r_d   = R_START;
          cnt_d = HALF;
        end
      end
      R_START: begin
        if (tick) begin
          if (!rx_s) begin
            r_d   = R_DATA;
            cnt_d = FULL;
            bit_d = '0;
          end else begin
            r_d = R_IDLE;
          end
        end
      end
      R_DATA: begin
        if (tick) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) r_d = R_STOP;
        end
      end
      R_STOP: begin
        if (tick) begin
          if (rx_s) rx_valid_d = 1'b1;
          else      ferr_d     = 1'b1;
          r_d = R_IDLE;
        end
      end
      default: r_d = R_IDLE;
    endcase
  end

  pstate_e    p_q, p_d;
  logic [7:0] addr_q, addr_d, data_q, data_d, sum_q, sum_d;
  logic [8:0] len_q, len_d, bcnt_q, bcnt_d;
  logic       we_q, we_d, hold_q, hold_d;
  logic       busy_q, busy_d, err_q, err_d;
  logic       in_pkt;

  assign in_pkt = (p_q == P_LEN) || (p_q == P_DATA) || (p_q == P_CSUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= P_SYNC;
      addr_q <= '0;
      data_q <= '0;
      sum_q  <= '0;
      len_q  <= '0;
      bcnt_q <= '0;
      we_q   <= 1'b0;
      hold_q <= 1'b1;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      p_q    <= p_d;
      addr_q <= addr_d;
      data_q <= data_d;
      sum_q  <= sum_d;
      len_q  <= len_d;
      bcnt_q <= bcnt_d;
      we_q   <= we_d;
      hold_q <= hold_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // Address advances the cycle after each strobe.
  always_comb begin
    p_d    = p_q;
    addr_d = we_q ? addr_q + 8'd1 : addr_q;
    data_d = data_q;
    sum_d  = sum_q;
    len_d  = len_q;
    bcnt_d = bcnt_q;
    we_d   = 1'b0;
    hold_d = hold_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (ferr_q) begin
      if (in_pkt) begin
        err_d  = 1'b1;
        busy_d = 1'b0;
        p_d    = P_SYNC;
      end
    end else if (rx_valid_q) begin
      unique case (p_q)
        P_SYNC, P_RUN: begin
          if (shreg_q == SYNC_BYTE) begin
            p_d    = P_LEN;
            err_d  = 1'b0;
            hold_d = 1'b1;
            busy_d = 1'b1;
            addr_d = '0;
            bcnt_d = '0;
            sum_d  = '0;
          end
        end
        P_LEN: begin
          len_d = (shreg_q == 8'd0) ? 9'd256 : {1'b0, shreg_q};
          p_d   = P_DATA;
        end
        P_DATA: begin
          data_d = shreg_q;
          we_d   = 1'b1;
          sum_d  = sum_q + shreg_q;
          bcnt_d = bcnt_q + 9'd1;
          if (bcnt_q + 9'd1 == len_q) p_d = P_CSUM;
        end
        P_CSUM: begin
          busy_d = 1'b0;
          if (shreg_q == sum_q) begin
            p_d    = P_RUN;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
            p_d   = P_SYNC;
          end
        end
        default: p_d = P_SYNC;
      endcase
    end
  end

  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign ram_we   = we_q;
  assign cpu_hold = hold_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign byte_cnt = bcnt_q;

endmodule

// File: tb/tb_prog_loader_uart.sv
// tb_prog_loader_uart: directed bench for the UART boot loader.
// Writes are checked against a queue of expected (addr, data) pairs.
module tb_prog_loader_uart;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] ram_addr, ram_data;
  logic       ram_we, cpu_hold, busy, err;
  logic [8:0] byte_cnt;

  int checks = 0;
  int passed = 0;
  int wr_seen = 0;
  logic prev_we = 1'b0;
  logic [15:0] exp_q[$];

  prog_loader_uart #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .busy(busy), .err(err), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic bit_time(input logic v);
    rx_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic frame_head(input logic [7:0] b);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    frame_head(b);
    bit_time(stop);
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        wr_seen++;
        chk("we_width", {31'd0, prev_we}, 32'd0);
        chk("wr_pending", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, ram_addr}, {24'd0, e[15:8]});
          chk("wr_data", {24'd0, ram_data}, {24'd0, e[7:0]});
        end
      end
      prev_we = ram_we;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_cnt", {23'd0, byte_cnt}, 32'd0);
    idle(200);
    chk("idle_writes", wr_seen, 32'd0);

    // good packet, with a short glitch between payload bytes
    push(8'h00, 8'h42); push(8'h01, 8'h05); push(8'h02, 8'h07);
    send_byte(8'hA5);
    idle(5);
    chk("sync_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h03);
    send_byte(8'h42);
    idle(20);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(100);
    chk("glitch_err", {31'd0, err}, 32'd0);
    chk("glitch_cnt", {23'd0, byte_cnt}, 32'd1);
    send_byte(8'h05);
    send_byte(8'h07);
    send_byte(8'h4E);
    idle(10);
    chk("p1_cnt", {23'd0, byte_cnt}, 32'd3);
    chk("p1_hold", {31'd0, cpu_hold}, 32'd0);
    chk("p1_err", {31'd0, err}, 32'd0);
    chk("p1_busy", {31'd0, busy}, 32'd0);
    chk("p1_addr", {24'd0, ram_addr}, 32'd3);

    // framing error while running is ignored
    send_byte(8'h3C, 1'b0);
    idle(20);
    chk("run_ferr_err", {31'd0, err}, 32'd0);
    chk("run_ferr_hold", {31'd0, cpu_hold}, 32'd0);

    // bad checksum, then recovery
    push(8'h00, 8'h11); push(8'h01, 8'h22);
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h00);
    idle(10);
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_hold", {31'd0, cpu_hold}, 32'd1);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    chk("bad_cnt", {23'd0, byte_cnt}, 32'd2);
    push(8'h00, 8'h10);
    send_byte(8'hA5);
    idle(5);
    chk("resync_err", {31'd0, err}, 32'd0);
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h10);
    idle(10);
    chk("rec_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rec_err", {31'd0, err}, 32'd0);

    // 256-byte image
    for (int i = 0; i < 256; i++) push(8'(i), 8'h01);
    send_byte(8'hA5); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'h01);
    idle(5);
    chk("big_addr", {24'd0, ram_addr}, 32'd0);
    chk("big_cnt", {23'd0, byte_cnt}, 32'd256);
    chk("big_hold_pre", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h00);
    idle(10);
    chk("big_hold", {31'd0, cpu_hold}, 32'd0);
    chk("big_err", {31'd0, err}, 32'd0);

    // framing error inside payload
    push(8'h00, 8'h33);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h33);
    send_byte(8'h44, 1'b0);
    idle(20);
    chk("fe_err", {31'd0, err}, 32'd1);
    chk("fe_busy", {31'd0, busy}, 32'd0);
    chk("fe_hold", {31'd0, cpu_hold}, 32'd1);
    chk("fe_cnt", {23'd0, byte_cnt}, 32'd1);
    send_byte(8'h10);
    idle(20);
    chk("fe_sync_ignore", {23'd0, byte_cnt}, 32'd1);

    // reload while running: hold returns right after the sync byte
    push(8'h00, 8'h10);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h10); send_byte(8'h10);
    idle(10);
    chk("run_hold", {31'd0, cpu_hold}, 32'd0);
    frame_head(8'hA5);
    chk("run_sync_pre", {31'd0, cpu_hold}, 32'd0);
    bit_time(1'b1);
    idle(3);
    chk("run_sync_hold", {31'd0, cpu_hold}, 32'd1);
    chk("run_sync_busy", {31'd0, busy}, 32'd1);

    // reset in the middle of a byte
    push(8'h00, 8'h55);
    send_byte(8'h02); send_byte(8'h55);
    idle(5);
    chk("pre_rst_cnt", {23'd0, byte_cnt}, 32'd1);
    bit_time(1'b0); bit_time(1'b0); bit_time(1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_addr", {24'd0, ram_addr}, 32'd0);
    chk("mid_rst_data", {24'd0, ram_data}, 32'd0);
    chk("mid_rst_we", {31'd0, ram_we}, 32'd0);
    chk("mid_rst_cnt", {23'd0, byte_cnt}, 32'd0);
    rst = 1'b0;
    idle(100);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
